// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State codes, datapath widths and the sequential PC step.
package fetch_unit_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [WORD-1:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    FETCH_RESET = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_VALID = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select: sequential step or word-offset branch target.
// Pure combinational so a pipelined fetch can reuse it.
module pc_next_logic
  import fetch_unit_pkg::*;
(
  input  logic [WORD-1:0] pc,
  input  logic            unconditional_branch,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic [WORD-1:0] extended_instruction,
  output logic [WORD-1:0] next_pc
);

  logic            take;
  logic [WORD-1:0] target;
  logic [WORD-1:0] seq;

  assign take   = unconditional_branch
                | (branch & alu_zero);
  assign target = pc
                + (extended_instruction << 2);
  assign seq    = pc + PC_STEP;

  assign next_pc = take ? target : seq;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem req/ack handshake, held instruction,
// sticky fault on error or timeout, retired-instruction count.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 64'h0,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic                 imem_err,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic [INSTR_LEN-1:0] instruction,
  output logic                 instr_valid,
  output logic [WORD-1:0]      pc,
  input  logic                 retire,
  input  logic                 unconditional_branch,
  input  logic                 branch,
  input  logic                 alu_zero,
  input  logic [WORD-1:0]      extended_instruction,
  output logic                 fault,
  output logic [31:0]          retired_count
);

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [7:0]      tcnt;
  logic [7:0]      tcnt_inc;
  logic [WORD-1:0] next_pc;
  logic            in_fetch;
  logic            fetch_ok;
  logic            fetch_bad;
  logic            expire;
  logic            retire_ok;

  pc_next_logic u_pc_next (
    .pc                   (pc),
    .unconditional_branch (unconditional_branch),
    .branch               (branch),
    .alu_zero             (alu_zero),
    .extended_instruction (extended_instruction),
    .next_pc              (next_pc)
  );

  assign in_fetch  = (state == FETCH_FETCH);
  assign tcnt_inc  = tcnt + 8'd1;
  assign fetch_ok  = in_fetch & imem_ack & ~imem_err;
  // An ack in the expiry cycle takes priority over the timeout.
  assign fetch_bad = in_fetch & imem_ack & imem_err;
  assign expire    = in_fetch & ~imem_ack
                   & (tcnt_inc == TMO);
  assign retire_ok = (state == FETCH_VALID) & retire;

  assign imem_addr = pc;
  assign fault     = (state == FETCH_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_RESET;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      FETCH_RESET: state_nx = FETCH_FETCH;
      FETCH_FETCH: begin
        imem_req = 1'b1;
        if (fetch_ok)
          state_nx = FETCH_VALID;
        else if (fetch_bad | expire)
          state_nx = FETCH_FAULT;
      end
      FETCH_VALID: begin
        instr_valid = 1'b1;
        if (retire_ok) state_nx = FETCH_FETCH;
      end
      FETCH_FAULT: state_nx = FETCH_FAULT;
      default:     state_nx = FETCH_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      instruction   <= '0;
      retired_count <= '0;
      tcnt          <= '0;
    end else begin
      if (fetch_ok)
        instruction <= imem_rdata;
      if (retire_ok) begin
        pc            <= next_pc;
        retired_count <= retired_count + 32'd1;
      end
      if ((state_nx == FETCH_FETCH) && !in_fetch)
        tcnt <= '0;
      else if (in_fetch && !imem_ack)
        tcnt <= tcnt_inc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem responder,
// scoreboard of expected (pc, instruction) pairs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_err = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic        retire = 1'b0;
  logic        ubr = 1'b0;
  logic        br = 1'b0;
  logic        az = 1'b0;
  logic [63:0] ext = '0;
  logic        fault;
  logic [31:0] retired_count;

  int errors = 0;
  int checks = 0;

  logic [95:0] sb[$];

  fetch_unit #(
    .RESET_PC (64'h100),
    .TIMEOUT  (8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_ack             (imem_ack),
    .imem_err             (imem_err),
    .imem_rdata           (imem_rdata),
    .instruction          (instruction),
    .instr_valid          (instr_valid),
    .pc                   (pc),
    .retire               (retire),
    .unconditional_branch (ubr),
    .branch               (br),
    .alu_zero             (az),
    .extended_instruction (ext),
    .fault                (fault),
    .retired_count        (retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic serve(input logic [63:0] addr,
                       input logic [31:0] data,
                       input int lat,
                       input bit err);
    logic [95:0] e;
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_wait", 64'(imem_req), 64'd1);
      return;
    end
    chk("addr", imem_addr, addr);
    repeat (lat) @(negedge clk);
    chk("req_held", 64'(imem_req), 64'd1);
    imem_ack   = 1'b1;
    imem_rdata = data;
    imem_err   = err;
    if (!err) sb.push_back({addr, data});
    chk("valid_at_ack", 64'(instr_valid), 64'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_err = 1'b0;
    if (err) begin
      chk("err_fault", 64'(fault), 64'd1);
      chk("err_req", 64'(imem_req), 64'd0);
      chk("err_pc", pc, addr);
    end else begin
      chk("valid", 64'(instr_valid), 64'd1);
      chk("no_fault", 64'(fault), 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("instr", 64'(instruction), 64'(e[31:0]));
        chk("pc", pc, e[95:32]);
      end
    end
  endtask

  task automatic do_retire(input bit u,
                           input bit b,
                           input bit z,
                           input logic [63:0] x);
    retire = 1'b1;
    ubr = u;
    br  = b;
    az  = z;
    ext = x;
    @(negedge clk);
    retire = 1'b0;
    ubr = 1'b0;
    br  = 1'b0;
    az  = 1'b0;
    ext = '0;
    chk("valid_drop", 64'(instr_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cnt", 64'(retired_count), 64'd0);
    chk("rst_pc", pc, 64'h100);
    chk("rst_instr", 64'(instruction), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    serve(64'h100, 32'hF84003E9, 2, 1'b0);
    // branch inputs without retire must not move the PC
    ubr = 1'b1;
    ext = 64'h40;
    repeat (2) @(negedge clk);
    ubr = 1'b0;
    ext = '0;
    chk("hold_pc", pc, 64'h100);
    chk("hold_valid", 64'(instr_valid), 64'd1);

    do_retire(1'b0, 1'b0, 1'b0, 64'h0);
    chk("cnt1", 64'(retired_count), 64'd1);
    // ack lands in the expiry cycle: ack wins
    serve(64'h104, 32'h00000013, 7, 1'b0);

    do_retire(1'b0, 1'b1, 1'b1, -64'sd2);
    serve(64'hFC, 32'h11111111, 0, 1'b0);
    do_retire(1'b0, 1'b1, 1'b0, -64'sd2);
    serve(64'h100, 32'h22222222, 1, 1'b0);
    do_retire(1'b1, 1'b0, 1'b0, 64'h10);
    serve(64'h140, 32'h33333333, 3, 1'b0);
    do_retire(1'b1, 1'b0, 1'b0, -64'sd81);
    serve(64'hFFFF_FFFF_FFFF_FFFC,
          32'h44444444, 1, 1'b0);
    do_retire(1'b0, 1'b0, 1'b0, 64'h0);
    serve(64'h0, 32'h55555555, 2, 1'b0);
    chk("cnt6", 64'(retired_count), 64'd6);

    do_retire(1'b0, 1'b0, 1'b0, 64'h0);
    cyc = 0;
    while (imem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_cycles", 64'(cyc), 64'd8);
    chk("tmo_fault", 64'(fault), 64'd1);
    chk("tmo_req", 64'(imem_req), 64'd0);
    chk("tmo_pc", pc, 64'h4);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    retire     = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    retire   = 1'b0;
    @(negedge clk);
    chk("flt_fault", 64'(fault), 64'd1);
    chk("flt_valid", 64'(instr_valid), 64'd0);
    chk("flt_pc", pc, 64'h4);
    chk("flt_cnt", 64'(retired_count), 64'd7);
    chk("flt_instr", 64'(instruction), 64'h55555555);

    do_reset();
    chk("rst2_fault", 64'(fault), 64'd0);
    chk("rst2_cnt", 64'(retired_count), 64'd0);
    serve(64'h100, 32'h66666666, 1, 1'b1);
    repeat (2) @(negedge clk);
    chk("err_sticky", 64'(fault), 64'd1);

    do_reset();
    serve(64'h100, 32'h77777777, 1, 1'b0);
    do_retire(1'b0, 1'b0, 1'b0, 64'h0);
    chk("pre_cnt", 64'(retired_count), 64'd1);
    chk("pre_req", 64'(imem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req", 64'(imem_req), 64'd0);
    chk("async_pc", pc, 64'h100);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBADBAD00;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_valid", 64'(instr_valid), 64'd0);
    chk("late_cnt", 64'(retired_count), 64'd0);
    chk("late_instr", 64'(instruction), 64'd0);
    serve(64'h100, 32'h88888888, 2, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
